// File: rtl/sound_mixer.sv
// sound_mixer: four-channel APU mixer. Converts each channel's 4-bit level to a
// signed DAC value, pans it via NR51 into left/right accumulators (one channel
// per cycle), scales by the NR50 master volume and emits signed 16-bit PCM.
//
// Optional build macro: SOUND_MIXER_HPF_EN adds a DC-blocking high-pass stage
// after SCALE (one extra cycle of latency and of minimum tick spacing).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sample_tick           one-cycle request for a new sample
//   ch1..ch4_level        4-bit channel levels
//   ch_enable             per-channel DAC enable (bit i = channel i+1)
//   nr50                  [6:4] left volume, [2:0] right volume
//   nr51                  [7:4] left routing ch4..ch1, [3:0] right routing
//   master_en             NR52 master enable
//   left, right           signed 16-bit samples (held between updates)
//   sample_valid          one-cycle pulse with each new left/right
//   overrun               one-cycle pulse when a tick arrives while busy
module sound_mixer #(
  parameter int unsigned OUT_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [3:0]  ch1_level,
  input  logic [3:0]  ch2_level,
  input  logic [3:0]  ch3_level,
  input  logic [3:0]  ch4_level,
  input  logic [3:0]  ch_enable,
  input  logic [7:0]  nr50,
  input  logic [7:0]  nr51,
  input  logic        master_en,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned DAC_W  = 6;
  localparam int unsigned ACC_W  = 7;
  localparam int unsigned VOL_W  = 5;
  localparam int unsigned PROD_W = 10;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_ACC0  = 3'd1;
  localparam logic [ST_W-1:0] S_ACC1  = 3'd2;
  localparam logic [ST_W-1:0] S_ACC2  = 3'd3;
  localparam logic [ST_W-1:0] S_ACC3  = 3'd4;
  localparam logic [ST_W-1:0] S_SCALE = 3'd5;
`ifdef SOUND_MIXER_HPF_EN
  localparam logic [ST_W-1:0] S_HPF   = 3'd6;
`endif

  logic [ST_W-1:0] state, next_state;

  // Snapshot of all inputs taken when a tick is accepted
  logic [15:0] snap_lvl;
  logic [3:0]  snap_en;
  logic [7:0]  snap_route;
  logic [2:0]  snap_vol_l, snap_vol_r;
  logic        snap_master;

  logic signed [ACC_W-1:0] acc_l, acc_r;

  // One-cycle output staging so outputs land exactly one edge after SCALE/HPF
  logic signed [OUT_W-1:0] pend_l, pend_r;
  logic                    pend_v;

  // Vin bits of NR50 have no effect on the mix
  logic unused_vin;
  assign unused_vin = ^{nr50[7], nr50[3]};

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (sample_tick) next_state = S_ACC0;
      S_ACC0:  next_state = S_ACC1;
      S_ACC1:  next_state = S_ACC2;
      S_ACC2:  next_state = S_ACC3;
      S_ACC3:  next_state = S_SCALE;
`ifdef SOUND_MIXER_HPF_EN
      S_SCALE: next_state = S_HPF;
      S_HPF:   next_state = S_IDLE;
`else
      S_SCALE: next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Per-channel DAC value for the channel being accumulated this cycle
  logic [1:0]              ch_idx_c;
  logic [3:0]              lvl_c;
  logic signed [DAC_W-1:0] dac_c;
  logic                    route_l_c, route_r_c;

  always_comb begin
    ch_idx_c  = 2'(state - S_ACC0);
    lvl_c     = snap_lvl[{ch_idx_c, 2'b00} +: 4];
    dac_c     = '0;
    if (snap_en[ch_idx_c])
      dac_c = $signed({1'b0, lvl_c, 1'b0}) - 6'sd15;
    route_l_c = snap_route[{1'b1, ch_idx_c}];
    route_r_c = snap_route[{1'b0, ch_idx_c}];
  end

  // Volume scaling: acc * (vol+1), then shift to output scale
  logic signed [VOL_W-1:0]  vol_l_c, vol_r_c;
  logic signed [PROD_W-1:0] prod_l_c, prod_r_c;
  logic signed [OUT_W-1:0]  scaled_l_c, scaled_r_c;

  always_comb begin
    vol_l_c    = $signed({2'b00, snap_vol_l}) + 5'sd1;
    vol_r_c    = $signed({2'b00, snap_vol_r}) + 5'sd1;
    prod_l_c   = PROD_W'(acc_l) * PROD_W'(vol_l_c);
    prod_r_c   = PROD_W'(acc_r) * PROD_W'(vol_r_c);
    scaled_l_c = '0;
    scaled_r_c = '0;
    if (snap_master) begin
      scaled_l_c = OUT_W'(prod_l_c) <<< OUT_SHIFT;
      scaled_r_c = OUT_W'(prod_r_c) <<< OUT_SHIFT;
    end
  end

`ifdef SOUND_MIXER_HPF_EN
  localparam int unsigned HPF_W = 18;

  logic signed [OUT_W-1:0] x_l, x_r, xp_l, xp_r, yp_l, yp_r;
  logic signed [HPF_W-1:0] y_l_wide_c, y_r_wide_c;
  logic signed [OUT_W-1:0] y_l_c, y_r_c;

  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [HPF_W-1:0] v);
    if (v > 18'sd32767)       sat16 = 16'sh7FFF;
    else if (v < -18'sd32768) sat16 = 16'sh8000;
    else                      sat16 = OUT_W'(v);
  endfunction

  // y = x - x_prev + y_prev - y_prev/256, one pole just below DC
  always_comb begin
    y_l_wide_c = HPF_W'(x_l) - HPF_W'(xp_l) + HPF_W'(yp_l) - HPF_W'(yp_l >>> 8);
    y_r_wide_c = HPF_W'(x_r) - HPF_W'(xp_r) + HPF_W'(yp_r) - HPF_W'(yp_r >>> 8);
    y_l_c      = sat16(y_l_wide_c);
    y_r_c      = sat16(y_r_wide_c);
  end
`endif

  // Datapath: snapshot, accumulate, scale, output staging
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_lvl     <= '0;
      snap_en      <= '0;
      snap_route   <= '0;
      snap_vol_l   <= '0;
      snap_vol_r   <= '0;
      snap_master  <= 1'b0;
      acc_l        <= '0;
      acc_r        <= '0;
      pend_l       <= '0;
      pend_r       <= '0;
      pend_v       <= 1'b0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef SOUND_MIXER_HPF_EN
      x_l  <= '0;
      x_r  <= '0;
      xp_l <= '0;
      xp_r <= '0;
      yp_l <= '0;
      yp_r <= '0;
`endif
    end else begin
      pend_v       <= 1'b0;
      sample_valid <= pend_v;
      overrun      <= sample_tick && (state != S_IDLE);
      if (pend_v) begin
        left  <= pend_l;
        right <= pend_r;
      end
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            snap_lvl    <= {ch4_level, ch3_level, ch2_level, ch1_level};
            snap_en     <= ch_enable;
            snap_route  <= nr51;
            snap_vol_l  <= nr50[6:4];
            snap_vol_r  <= nr50[2:0];
            snap_master <= master_en;
            acc_l       <= '0;
            acc_r       <= '0;
          end
        end
        S_ACC0, S_ACC1, S_ACC2, S_ACC3: begin
          if (route_l_c) acc_l <= acc_l + ACC_W'(dac_c);
          if (route_r_c) acc_r <= acc_r + ACC_W'(dac_c);
        end
        S_SCALE: begin
`ifdef SOUND_MIXER_HPF_EN
          x_l <= scaled_l_c;
          x_r <= scaled_r_c;
`else
          pend_l <= scaled_l_c;
          pend_r <= scaled_r_c;
          pend_v <= 1'b1;
`endif
        end
`ifdef SOUND_MIXER_HPF_EN
        S_HPF: begin
          pend_l <= y_l_c;
          pend_r <= y_r_c;
          pend_v <= 1'b1;
          xp_l   <= x_l;
          xp_r   <= x_r;
          yp_l   <= y_l_c;
          yp_r   <= y_r_c;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
